// File: rtl/dp_ram_pkg.sv
// Shared sizing and types for dp_ram and the FIFO controller that drives it.
package dp_ram_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W:0]   cnt_t;
endpackage

// File: rtl/dp_ram_rdbuf.sv
// Two-entry in-order buffer catching RAM read data; head is always entry 0.
module dp_ram_rdbuf
  import dp_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        cnt
);
  data_t e0, e1;

  assign head = e0;

  // Pop is only ever requested with cnt != 0 and push never overflows, so
  // the unlisted corner cases need no handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// Streams bytes through an external 1R/1W dp_ram as a FIFO, hiding its read latency.
module dp_ram_fifo_ctrl
  import dp_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic [ADDR_W:0]   count
);
  addr_t      wr_ptr, rd_ptr;
  cnt_t       mem_cnt;
  logic       inflight;
  logic [1:0] ob_cnt;
  logic       run;
  logic       pop;
  logic       wr_fire;

  assign count = mem_cnt + cnt_t'(inflight) + cnt_t'(ob_cnt);

  // run keeps s_ready low through reset and for the edge that releases it.
  assign s_ready     = run && (count < cnt_t'(DEPTH));
  assign wr_fire     = s_valid && s_ready;
  assign ram_wr_en   = wr_fire;
  assign ram_wr_addr = wr_ptr;
  assign ram_w_data  = s_data;

  assign m_valid = (ob_cnt != 2'd0);
  assign pop     = m_valid && m_ready;

  // Issue only if the buffer will have room once this read returns.
  assign ram_rd_en   = (mem_cnt != '0) &&
                       ((3'(ob_cnt) + 3'(inflight)) < (3'd2 + 3'(pop)));
  assign ram_rd_addr = rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      run      <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= ram_rd_en;
      if (wr_fire)   wr_ptr <= wr_ptr + addr_t'(1);
      if (ram_rd_en) rd_ptr <= rd_ptr + addr_t'(1);
      case ({wr_fire, ram_rd_en})
        2'b10:   mem_cnt <= mem_cnt + cnt_t'(1);
        2'b01:   mem_cnt <= mem_cnt - cnt_t'(1);
        default: ;
      endcase
    end
  end

  dp_ram_rdbuf u_rdbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_r_data),
    .pop       (pop),
    .head      (m_data),
    .cnt       (ob_cnt)
  );
endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_dp_ram_fifo_ctrl;
  import dp_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic s_valid, s_ready, m_valid, m_ready;
  data_t s_data, m_data, ram_w_data, ram_r_data;
  logic ram_wr_en, ram_rd_en;
  addr_t ram_wr_addr, ram_rd_addr;
  logic [ADDR_W:0] count;

  always #5 clk = ~clk;

  dp_ram_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_w_data(ram_w_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_r_data(ram_r_data),
    .count(count)
  );

  // Behavioural 1R/1W RAM with registered read.
  data_t ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    ram_r_data = '0;
  end
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_w_data;
    if (ram_rd_en) ram_r_data <= ram[ram_rd_addr];
  end

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  data_t q[$];
  int pop_calls[$];
  int call_idx = 0;
  logic stalled = 1'b0;
  data_t stall_data = '0;
  logic acc, pp;
  logic obs_rd_en, obs_wr_en, obs_mv, obs_sr;
  addr_t obs_rd_addr, obs_wr_addr;
  data_t obs_md;
  logic [ADDR_W:0] obs_count;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; checks against the queue model, then advances it.
  task automatic cycle(input logic sv, input data_t sd, input logic mr);
    @(negedge clk);
    s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    obs_rd_en = ram_rd_en; obs_rd_addr = ram_rd_addr; obs_wr_en = ram_wr_en;
    obs_wr_addr = ram_wr_addr; obs_mv = m_valid; obs_md = m_data;
    obs_sr = s_ready; obs_count = count;
    chk("count", 32'(count), 32'(q.size()));
    chk("s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
    chk("wr_en", 32'(ram_wr_en), 32'(sv && (q.size() < DEPTH)));
    if (stalled) begin
      chk("stall_valid", 32'(m_valid), 32'(1));
      chk("stall_data", 32'(m_data), 32'(stall_data));
    end
    if (m_valid) begin
      chk("valid_nonempty", 32'(q.size() != 0), 32'(1));
      if (q.size() != 0) chk("order", 32'(m_data), 32'(q[0]));
    end
    acc = sv && s_ready;
    pp  = m_valid && mr;
    stalled = m_valid && !mr;
    stall_data = m_data;
    @(posedge clk);
    if (pp) begin
      if (q.size() != 0) void'(q.pop_front());
      pop_calls.push_back(call_idx);
    end
    if (acc) q.push_back(sd);
    call_idx++;
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'(0));
    chk({tag, "_m_valid"}, 32'(m_valid), 32'(0));
    chk({tag, "_m_data"}, 32'(m_data), 32'(0));
    chk({tag, "_wr_en"}, 32'(ram_wr_en), 32'(0));
    chk({tag, "_rd_en"}, 32'(ram_rd_en), 32'(0));
    chk({tag, "_wr_addr"}, 32'(ram_wr_addr), 32'(0));
    chk({tag, "_rd_addr"}, 32'(ram_rd_addr), 32'(0));
    chk({tag, "_count"}, 32'(count), 32'(0));
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 100 && q.size() != 0; n++) cycle(1'b0, '0, 1'b1);
    chk(tag, 32'(q.size()), 32'(0));
  endtask

  initial begin
    int sent;
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'h5A; m_ready = 1'b1;
    #1;
    zero_checks("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; rst_n = 1'b1;
    #1 chk("release_s_ready_low", 32'(s_ready), 32'(0));

    // Single byte latency
    cycle(1'b1, 8'hA5, 1'b1);
    chk("first_sready", 32'(obs_sr), 32'(1));
    chk("wr_addr0", 32'(obs_wr_addr), 32'(0));
    cycle(1'b0, '0, 1'b1);
    chk("rd_en_e1", 32'(obs_rd_en), 32'(1));
    chk("rd_addr_e1", 32'(obs_rd_addr), 32'(0));
    chk("mv_e1", 32'(obs_mv), 32'(0));
    cycle(1'b0, '0, 1'b1);
    chk("rd_en_idle", 32'(obs_rd_en), 32'(0));
    chk("mv_e2", 32'(obs_mv), 32'(0));
    cycle(1'b0, '0, 1'b1);
    chk("mv_e3", 32'(obs_mv), 32'(1));
    chk("md_a5", 32'(obs_md), 32'hA5);
    cycle(1'b0, '0, 1'b1);
    chk("count_after_pop", 32'(obs_count), 32'(0));
    chk("mv_after_pop", 32'(obs_mv), 32'(0));

    // Fill to full with consumer stalled
    for (int i = 0; i < 32; i++) cycle(1'b1, data_t'(i), 1'b0);
    repeat (2) begin
      cycle(1'b1, 8'h20, 1'b0);
      chk("full_s_ready", 32'(obs_sr), 32'(0));
      chk("full_wr_en", 32'(obs_wr_en), 32'(0));
      chk("full_count", 32'(obs_count), 32'(32));
    end
    cycle(1'b1, 8'h20, 1'b1);
    chk("pop_cycle_s_ready", 32'(obs_sr), 32'(0));
    cycle(1'b1, 8'h20, 1'b0);
    chk("after_pop_s_ready", 32'(obs_sr), 32'(1));
    drain("full_drain");

    // Back-to-back stream across three pointer wraps
    pop_calls.delete();
    call_idx = 0;
    for (int i = 0; i < 96; i++) cycle(1'b1, data_t'(i), 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    chk("stream_pops", 32'(pop_calls.size()), 32'(96));
    for (int i = 0; i < 96 && i < pop_calls.size(); i++)
      chk("stream_lat", 32'(pop_calls[i]), 32'(i + 3));

    // Random handshakes
    sent = 0;
    for (int n = 0; n < 3000 && sent < 200; n++) begin
      logic sv, mr;
      sv = ($urandom % 4) != 0;
      mr = (n % 200 < 60) ? 1'b0 : (($urandom % 3) != 0);
      cycle(sv, data_t'($urandom), mr);
      if (acc) sent++;
    end
    chk("rand_sent", 32'(sent), 32'(200));
    drain("rand_drain");

    // Reset in the middle of traffic
    for (int i = 0; i < 4; i++) cycle(1'b1, data_t'(8'hC0 + i), 1'b0);
    cycle(1'b1, 8'hC4, 1'b1);
    cycle(1'b1, 8'hC5, 1'b1);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 zero_checks("midrst");
    q.delete();
    stalled = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("midrst_release_s_ready", 32'(s_ready), 32'(0));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("midrst_no_stale", 32'(obs_mv), 32'(0));
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, data_t'(8'h70 + i), ($urandom % 2) == 0);
    drain("midrst_drain");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
